// File: rtl/matmul_op_sequencer.sv
// rtl/matmul_op_sequencer.sv - command sequencer for the systolic matmul datapath
module matmul_op_sequencer #(
    parameter int  DATA_WIDTH     = 8,
    parameter int  BUS_WIDTH      = 16,
    parameter int  SP_SEL_WIDTH   = 2,
    parameter int  TIMEOUT_CYCLES = 32,
    localparam int MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    localparam int NUM_PE         = MAX_DIM * MAX_DIM
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [1:0]              cmd_n_dim_i,
    input  logic [1:0]              cmd_k_dim_i,
    input  logic [1:0]              cmd_m_dim_i,
    input  logic                    cmd_mode_i,
    input  logic [SP_SEL_WIDTH-1:0] cmd_c_sel_i,
    input  logic [SP_SEL_WIDTH-1:0] cmd_dst_sel_i,
    output logic                    mul_start_o,
    output logic [1:0]              mul_n_dim_o,
    output logic [1:0]              mul_k_dim_o,
    output logic [1:0]              mul_m_dim_o,
    output logic                    mul_mode_o,
    input  logic                    mul_finish_i,
    input  logic [NUM_PE-1:0]       mul_flags_i,
    output logic [SP_SEL_WIDTH-1:0] sp_rd_sel_o,
    output logic                    sp_wr_en_o,
    output logic [SP_SEL_WIDTH-1:0] sp_wr_sel_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [NUM_PE-1:0]       flags_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_RUN,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              n_q, k_q, m_q;
    logic                    mode_q;
    logic [SP_SEL_WIDTH-1:0] c_sel_q, dst_q;
    logic [NUM_PE-1:0]       flags_q;
    logic [7:0]              tmo_q;
    logic                    dims_ok;

    function automatic logic dim_ok(input logic [1:0] d);
        return int'(d) < MAX_DIM;
    endfunction

    assign dims_ok = dim_ok(n_q) && dim_ok(k_q) && dim_ok(m_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i) state_d = S_CHECK;
            S_CHECK: state_d = dims_ok ? S_SETUP : S_ERR;
            S_SETUP: state_d = S_RUN;
            // finish wins over a timeout landing in the same cycle
            S_RUN: begin
                if (mul_finish_i)          state_d = S_WRITE;
                else if (tmo_q == TMO_LAST) state_d = S_ERR;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            mode_q  <= 1'b0;
            c_sel_q <= '0;
            dst_q   <= '0;
            flags_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && cmd_valid_i) begin
                n_q     <= cmd_n_dim_i;
                k_q     <= cmd_k_dim_i;
                m_q     <= cmd_m_dim_i;
                mode_q  <= cmd_mode_i;
                c_sel_q <= cmd_c_sel_i;
                dst_q   <= cmd_dst_sel_i;
                flags_q <= '0;
            end
            if (state_q == S_RUN) begin
                tmo_q <= tmo_q + 8'd1;
                if (mul_finish_i) flags_q <= mul_flags_i;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // every output is a decode of state or a register: no input-to-output path
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign mul_start_o = (state_q == S_RUN) || (state_q == S_WRITE);
    assign sp_wr_en_o  = (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);
    assign mul_n_dim_o = n_q;
    assign mul_k_dim_o = k_q;
    assign mul_m_dim_o = m_q;
    assign mul_mode_o  = mode_q;
    assign flags_o     = flags_q;
    assign sp_wr_sel_o = (state_q == S_WRITE) ? dst_q : '0;
    assign sp_rd_sel_o = (state_q == S_SETUP || state_q == S_RUN || state_q == S_WRITE)
                         ? c_sel_q : '0;

endmodule

// File: tb/tb_matmul_op_sequencer.sv
// tb/tb_matmul_op_sequencer.sv - randomized schedule-model bench for matmul_op_sequencer
module tb_matmul_op_sequencer;

    localparam int TO    = 32;
    localparam int MAXI  = 16 / 8 - 1;
    localparam int DEPTH = 4096;

    typedef struct packed {
        logic       valid;
        logic [1:0] n, k, m;
        logic       mode;
        logic [1:0] csel, dst;
        logic       fin;
        logic [3:0] fl;
    } stim_t;

    typedef struct packed {
        logic       busy, start, wr, done, err, win, fset;
        logic [1:0] wrsel, rdsel, n, k, m;
        logic       mode;
        logic [3:0] fval;
    } exp_t;

    typedef struct packed {
        logic       ready, start, wr, done, err;
        logic [1:0] wrsel, rdsel;
        logic [3:0] flags;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_ni;
    logic       cmd_valid_i, cmd_ready_o;
    logic [1:0] cmd_n_dim_i, cmd_k_dim_i, cmd_m_dim_i;
    logic       cmd_mode_i;
    logic [1:0] cmd_c_sel_i, cmd_dst_sel_i;
    logic       mul_start_o;
    logic [1:0] mul_n_dim_o, mul_k_dim_o, mul_m_dim_o;
    logic       mul_mode_o, mul_finish_i;
    logic [3:0] mul_flags_i;
    logic [1:0] sp_rd_sel_o, sp_wr_sel_o;
    logic       sp_wr_en_o, busy_o, done_o, err_o;
    logic [3:0] flags_o;

    matmul_op_sequencer #(
        .DATA_WIDTH(8), .BUS_WIDTH(16), .SP_SEL_WIDTH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_n_dim_i(cmd_n_dim_i), .cmd_k_dim_i(cmd_k_dim_i), .cmd_m_dim_i(cmd_m_dim_i),
        .cmd_mode_i(cmd_mode_i), .cmd_c_sel_i(cmd_c_sel_i), .cmd_dst_sel_i(cmd_dst_sel_i),
        .mul_start_o(mul_start_o),
        .mul_n_dim_o(mul_n_dim_o), .mul_k_dim_o(mul_k_dim_o), .mul_m_dim_o(mul_m_dim_o),
        .mul_mode_o(mul_mode_o), .mul_finish_i(mul_finish_i), .mul_flags_i(mul_flags_i),
        .sp_rd_sel_o(sp_rd_sel_o), .sp_wr_en_o(sp_wr_en_o), .sp_wr_sel_o(sp_wr_sel_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .flags_o(flags_o)
    );

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    stim_t st[DEPTH];
    exp_t  ex[DEPTH];
    obs_t  hist[DEPTH];
    bit    in_run[DEPTH];
    int    idle_from, last_h, base, end_c;
    int    n_checks = 0;
    int    n_errors = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    // Schedule one command from the timing rules: accept in the first idle
    // cycle at or after v, then CHECK, SETUP, RUN..., WRITE/DONE or ERR.
    task automatic plan_cmd(input int v, input logic [1:0] n, k, m, csel, dst,
                            input logic mode, input int r, input logic [3:0] fl);
        int  h, last;
        bit  good, fin;
        h = (v > idle_from) ? v : idle_from;
        for (int c = v; c <= h; c++) begin
            st[c].valid = 1'b1; st[c].n = n; st[c].k = k; st[c].m = m;
            st[c].mode = mode; st[c].csel = csel; st[c].dst = dst;
        end
        good = (int'(n) <= MAXI) && (int'(k) <= MAXI) && (int'(m) <= MAXI);
        ex[h+1].busy = 1'b1; ex[h+1].fset = 1'b1; ex[h+1].fval = 4'b0;
        if (!good) begin
            ex[h+2].busy = 1'b1; ex[h+2].err = 1'b1;
            idle_from = h + 3;
        end else begin
            fin  = (r >= 0) && (r < TO);
            last = fin ? h + 3 + r : h + 2 + TO;
            for (int c = h + 2; c <= last + 1; c++) begin
                ex[c].busy = 1'b1;
                if (c <= last || fin) begin
                    ex[c].win = 1'b1; ex[c].rdsel = csel;
                    ex[c].n = n; ex[c].k = k; ex[c].m = m; ex[c].mode = mode;
                end
            end
            for (int c = h + 3; c <= last; c++) begin
                ex[c].start = 1'b1; in_run[c] = 1'b1;
            end
            if (fin) begin
                st[last].fin = 1'b1; st[last].fl = fl;
                ex[last+1].start = 1'b1; ex[last+1].wr = 1'b1; ex[last+1].wrsel = dst;
                ex[last+1].fset = 1'b1; ex[last+1].fval = fl;
                ex[last+2].busy = 1'b1; ex[last+2].done = 1'b1;
                idle_from = last + 3;
            end else begin
                ex[last+1].err = 1'b1;
                if (r == TO) st[last+1].fin = 1'b1;
                idle_from = last + 2;
            end
        end
        last_h = h;
    endtask

    function automatic logic [1:0] rdim();
        return ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    endfunction

    function automatic int count_start(input int a, input int z);
        int s = 0;
        for (int c = a; c <= z; c++) s += int'(hist[c].start);
        return s;
    endfunction

    function automatic int count_wr(input int a, input int z);
        int s = 0;
        for (int c = a; c <= z; c++) s += int'(hist[c].wr);
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_start"}, 32'(mul_start_o), 32'd0);
        chk({tag, "_wr"},    32'(sp_wr_en_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
        chk({tag, "_flags"}, 32'(flags_o), 32'd0);
        chk({tag, "_dims"},  32'({mul_n_dim_o, mul_k_dim_o, mul_m_dim_o, mul_mode_o}), 32'd0);
        chk({tag, "_sel"},   32'({sp_rd_sel_o, sp_wr_sel_o}), 32'd0);
    endtask

    initial begin
        exp_t       e;
        logic [3:0] cur_flags;
        cur_flags = 4'b0;
        forever begin
            @(negedge clk);
            if (chk_en && cyc < DEPTH) begin
                e = ex[cyc];
                if (e.fset) cur_flags = e.fval;
                hist[cyc] = '{cmd_ready_o, mul_start_o, sp_wr_en_o, done_o, err_o,
                              sp_wr_sel_o, sp_rd_sel_o, flags_o};
                chk("ready", 32'(cmd_ready_o), 32'(!e.busy));
                chk("busy",  32'(busy_o), 32'(e.busy));
                chk("start", 32'(mul_start_o), 32'(e.start));
                chk("wr_en", 32'(sp_wr_en_o), 32'(e.wr));
                chk("done",  32'(done_o), 32'(e.done));
                chk("err",   32'(err_o), 32'(e.err));
                chk("flags", 32'(flags_o), 32'(cur_flags));
                if (e.wr) chk("wr_sel", 32'(sp_wr_sel_o), 32'(e.wrsel));
                if (e.win) begin
                    chk("rd_sel", 32'(sp_rd_sel_o), 32'(e.rdsel));
                    chk("dims", 32'({mul_n_dim_o, mul_k_dim_o, mul_m_dim_o, mul_mode_o}),
                        32'({e.n, e.k, e.m, e.mode}));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  v, r, sel, started;
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_n_dim_i = '0; cmd_k_dim_i = '0; cmd_m_dim_i = '0;
        cmd_mode_i = 1'b0; cmd_c_sel_i = '0; cmd_dst_sel_i = '0;
        mul_finish_i = 1'b0; mul_flags_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");

        for (int c = 0; c < DEPTH; c++) begin
            ex[c] = '0; in_run[c] = 1'b0;
            st[c] = '0;
            st[c].n = 2'($urandom); st[c].k = 2'($urandom); st[c].m = 2'($urandom);
            st[c].mode = 1'($urandom); st[c].csel = 2'($urandom); st[c].dst = 2'($urandom);
            st[c].fl = 4'($urandom);
        end
        base = cyc;
        idle_from = base;
        plan_cmd(base + 1,   2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 1'b0, 4,      4'b0000);
        plan_cmd(last_h + 1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd1, 1'b0, 0,      4'b0000);
        plan_cmd(last_h + 1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 1'b0, -1,     4'b0000);
        plan_cmd(last_h + 1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 1'b1, 0,      4'b1001);
        plan_cmd(last_h + 1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd1, 1'b0, 0,      4'b0110);
        plan_cmd(last_h + 1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 1'b1, TO - 1, 4'b0011);
        plan_cmd(last_h + 1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, TO,     4'b1111);
        for (int i = 0; i < 40 && idle_from < DEPTH - 200; i++) begin
            sel = $urandom_range(0, 9);
            r   = (sel == 0) ? TO : (sel == 1) ? TO - 1 : $urandom_range(0, 6);
            v   = last_h + 1 + $urandom_range(0, 25);
            plan_cmd(v, rdim(), rdim(), rdim(), 2'($urandom), 2'($urandom),
                     1'($urandom), r, 4'($urandom));
        end
        end_c = idle_from + 3;
        for (int c = base + 1; c <= end_c; c++)
            if (!in_run[c] && $urandom_range(0, 5) == 0) st[c].fin = 1'b1;

        rst_ni = 1'b1;
        chk_en = 1'b1;
        while (cyc < end_c) begin
            @(posedge clk);
            #1;
            cmd_valid_i = st[cyc].valid;
            cmd_n_dim_i = st[cyc].n; cmd_k_dim_i = st[cyc].k; cmd_m_dim_i = st[cyc].m;
            cmd_mode_i = st[cyc].mode; cmd_c_sel_i = st[cyc].csel; cmd_dst_sel_i = st[cyc].dst;
            mul_finish_i = st[cyc].fin; mul_flags_i = st[cyc].fl;
        end
        @(negedge clk);
        chk_en = 1'b0;
        cmd_valid_i = 1'b0; mul_finish_i = 1'b0;

        // hand-derived timeline for the directed commands at the head of the plan
        chk("c0_start_len", 32'(count_start(base, base + 11)), 32'd6);
        chk("c0_wr_cycle",  32'({hist[base+9].wr, hist[base+9].wrsel}), 32'b110);
        chk("c0_wr_count",  32'(count_wr(base, base + 11)), 32'd1);
        chk("c0_done",      32'(hist[base+10].done), 32'd1);
        chk("c0_ready_ret", 32'({hist[base+10].ready, hist[base+11].ready}), 32'b01);
        chk("c1_err",       32'(hist[base+13].err), 32'd1);
        chk("c1_no_start",  32'(count_start(base + 11, base + 14)), 32'd0);
        chk("c1_ready_ret", 32'(hist[base+14].ready), 32'd1);
        chk("c2_start_len", 32'(count_start(base + 14, base + 50)), 32'd32);
        chk("c2_err",       32'(hist[base+49].err), 32'd1);
        chk("c2_no_wr",     32'(count_wr(base + 14, base + 50)), 32'd0);
        chk("c2_flags",     32'(hist[base+49].flags), 32'd0);
        chk("c3_rd_sel",    32'({hist[base+52].rdsel, hist[base+54].rdsel}), 32'b0101);
        chk("c3_flags_hold",32'(hist[base+56].flags), 32'b1001);
        chk("c4_flags_clr", 32'(hist[base+57].flags), 32'd0);
        chk("c4_gap",       32'({hist[base+58].start, hist[base+59].start}), 32'b01);
        chk("c4_done",      32'(hist[base+61].done), 32'd1);
        chk("c5_fin_prio",  32'({hist[base+96].start, hist[base+97].wr, hist[base+97].err}), 32'b110);
        chk("c6_timeout",   32'({count_start(base + 99, base + 135), 32'(hist[base+134].err)}), {32'd32, 32'd1});

        // asynchronous reset in the middle of a run
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_n_dim_i = 2'd0; cmd_k_dim_i = 2'd1; cmd_m_dim_i = 2'd0;
        cmd_mode_i = 1'b1; cmd_c_sel_i = 2'd2; cmd_dst_sel_i = 2'd3;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        started = 0;
        for (int i = 0; i < 10 && !mul_start_o; i++) begin
            @(posedge clk); #1;
        end
        started = int'(mul_start_o);
        chk("rst_run_reached", 32'(started), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;
        mul_finish_i = 1'b1; mul_flags_i = 4'b1111;
        @(posedge clk); #1;
        mul_finish_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_idle",
                32'({cmd_ready_o, mul_start_o, sp_wr_en_o, done_o, err_o, flags_o}),
                32'b1_0_0_0_0_0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/matmul_op_sequencer.md
Name: matmul_op_sequencer

Overview:
- Control FSM that sequences the systolic matrix-multiply datapath.
- Accepts one matmul command at a time over a valid/ready interface, configures dimensions and mode, and holds start through the run until finish is reported.
- Commands the scratchpad write-back of the result, then reports done/error and sticky overflow flags to the register-file/bus front end.
- Sits between the control-register block and the PE-array wrapper.

Parameters:
- DATA_WIDTH, 8, operand element width (passed through; sets MAX_DIM).
- BUS_WIDTH, 16, bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam).
- SP_SEL_WIDTH, 2, width of scratchpad slot select.
- TIMEOUT_CYCLES, 32, max RUN cycles before abort; 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  sequencer can accept a command.
- cmd_n_dim_i / cmd_k_dim_i / cmd_m_dim_i  in  2 each  dimension minus 1 (A is NxK, B is KxM).
- cmd_mode_i  in  1  1 = accumulate C operand from scratchpad, 0 = plain multiply.
- cmd_c_sel_i  in  SP_SEL_WIDTH  scratchpad slot supplying the C operand.
- cmd_dst_sel_i  in  SP_SEL_WIDTH  scratchpad slot receiving the result.
- mul_start_o  out  1  start to datapath.
- mul_n_dim_o / mul_k_dim_o / mul_m_dim_o  out  2 each  latched dims.
- mul_mode_o  out  1  latched mode.
- mul_finish_i  in  1  datapath finished.
- mul_flags_i  in  MAX_DIM*MAX_DIM  per-PE overflow.
- sp_rd_sel_o  out  SP_SEL_WIDTH  C-operand slot, held from SETUP through WRITE.
- sp_wr_en_o  out  1  result write strobe.
- sp_wr_sel_o  out  SP_SEL_WIDTH  result slot.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse on rejected or timed-out command.
- flags_o  out  MAX_DIM*MAX_DIM  overflow flags of last completed op.

Behaviour:
- Reset: rst_ni asynchronous, active-low. State goes to IDLE. All outputs and internal registers are 0, except cmd_ready_o = 1.
- States: IDLE, CHECK, SETUP, RUN, WRITE, DONE, ERR. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o: latch all cmd fields, clear flags_o to 0, go to CHECK.
- CHECK (1 cycle):
  - If any dim > MAX_DIM-1, go to ERR. Otherwise go to SETUP.
- SETUP (1 cycle):
  - mul_start_o = 0; dims, mode and sp_rd_sel_o driven from latched values.
  - This guarantees at least one start-low cycle so the datapath counter and PEs clear. Go to RUN.
- RUN:
  - mul_start_o = 1. An 8-bit timeout counter starts at 0 and increments each RUN cycle.
  - If mul_finish_i = 1: capture mul_flags_i into flags_o, go to WRITE.
  - Else, if counter == TIMEOUT_CYCLES-1: go to ERR.
  - Finish takes priority over timeout in the same cycle.
- WRITE (1 cycle):
  - mul_start_o stays 1 so results remain stable.
  - sp_wr_en_o = 1 with sp_wr_sel_o = latched dst. Go to DONE.
- DONE (1 cycle):
  - mul_start_o = 0, done_o = 1. Go to IDLE.
- ERR (1 cycle):
  - mul_start_o = 0, err_o = 1, no write, flags_o unchanged. Go to IDLE.
- Latency, accept edge T (cmd handshake sampled at T):
  - CHECK at T+1, SETUP at T+2.
  - mul_start_o first high at T+3.
  - Finish sampled at edge F gives sp_wr_en_o at F+1 and done_o at F+2.
  - cmd_ready_o returns high at F+3.
- mul_finish_i outside RUN is ignored. mul_flags_i is sampled only on the finish cycle.
- cmd_valid_i while busy is not accepted. The command stays pending until IDLE; there is no queueing.
- A command arriving in the same cycle the FSM re-enters IDLE is accepted on the next edge.
- Reset mid-operation: immediate return to IDLE, with mul_start_o, sp_wr_en_o, done_o and err_o all 0, and no partial write.
- Back-to-back commands: at least one start-low cycle (DONE plus SETUP) always separates two RUN phases.

Test Plan:
- Reset, then a legal cmd with n=1, k=1, m=1, mode=0, dst=2; finish driven 5 cycles after start rises, flags=4'b0000 -> start high exactly 6 cycles (5 RUN + WRITE); sp_wr_en_o=1 with sp_wr_sel_o=2 for 1 cycle; done_o 1 cycle later; err_o never asserted.
- Cmd with k=2 at default MAX_DIM=2 -> err_o pulse at T+2; start never rises; no write; cmd_ready_o back to 1 at T+3.
- Legal cmd with finish never asserted, TIMEOUT_CYCLES=32 -> start high exactly 32 cycles, then err_o pulse; no write; flags_o stays 0.
- Finish carrying flags=4'b1001 and mode=1, c_sel=1 -> sp_rd_sel_o=1 from SETUP through WRITE; flags_o=4'b1001 held until the next accept, then cleared to 0.
- Second cmd held valid during busy, finish asserted on RUN cycle 0 of each command -> second cmd accepted only after DONE; start low in DONE and SETUP between runs.
- rst_ni asserted during RUN -> all outputs 0 and cmd_ready_o=1 asynchronously; a later finish pulse is ignored; no write.
